// File: rtl/imsic_msi_fifo_ctrl.sv
// MSI identity FIFO controller around an external registered-read dual-port RAM.
// A 2-entry skid buffer hides the RAM read latency so the consumer sees full rate.
module imsic_msi_fifo_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wd,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rd,
  output logic [ADDR_W+1:0] count
);

  localparam int PW = ADDR_W + 1;
  localparam int CW = ADDR_W + 2;

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic              r_init_done;
  logic              r_inflight;
  logic [1:0]        r_skid_cnt;
  logic [DATA_W-1:0] r_skid0;
  logic [DATA_W-1:0] r_skid1;
  logic [CW-1:0]     r_count;

  logic [PW-1:0]     w_ram_cnt;
  logic              w_push;
  logic              w_pop;
  logic              w_fetch;
  logic [2:0]        w_occ;

  assign w_ram_cnt = r_wr_ptr - r_rd_ptr;
  assign in_ready  = r_init_done && (w_ram_cnt != PW'(DEPTH));
  assign w_push    = in_valid && in_ready;
  assign out_valid = r_skid_cnt != 2'd0;
  assign out_data  = r_skid0;
  assign w_pop     = out_valid && out_ready;

  // Words that will sit in the skid buffer after this edge if no new fetch.
  assign w_occ   = {1'b0, r_skid_cnt} + {2'b00, r_inflight}
                 - {2'b00, w_pop};
  assign w_fetch = (w_ram_cnt != '0) && (w_occ < 3'd2);

  assign ram_we    = w_push;
  assign ram_waddr = r_wr_ptr[ADDR_W-1:0];
  assign ram_wd    = in_data;
  assign ram_raddr = r_rd_ptr[ADDR_W-1:0];
  assign count     = r_count;

  // Init flag: producer is held off until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_init_done <= 1'b0;
    else     r_init_done <= 1'b1;
  end

  // RAM pointers, in-flight read marker and total occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_fetch) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_inflight <= w_fetch;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Skid buffer: entry 0 is the head, captured data queues behind survivors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid0    <= '0;
      r_skid1    <= '0;
      r_skid_cnt <= 2'd0;
    end else begin
      case ({w_pop, r_inflight})
        2'b01: begin
          if (r_skid_cnt == 2'd0) r_skid0 <= ram_rd;
          else                    r_skid1 <= ram_rd;
          r_skid_cnt <= r_skid_cnt + 2'd1;
        end
        2'b10: begin
          r_skid0    <= r_skid1;
          r_skid_cnt <= r_skid_cnt - 2'd1;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd2) begin
            r_skid0 <= r_skid1;
            r_skid1 <= ram_rd;
          end else begin
            r_skid0 <= ram_rd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imsic_msi_fifo_ctrl.sv
// Scoreboard bench for imsic_msi_fifo_ctrl with a behavioural registered-read RAM.
// Expected words are queued on accepted pushes and compared on pops.
module tb_imsic_msi_fifo_ctrl;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wd;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rd = '0;
  logic [ADDR_W+1:0] count;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sb [$];

  int  n_vec = 0;
  int  n_err = 0;
  bit  stream = 1'b0;
  bit  pushed;

  always #5 clk = ~clk;

  imsic_msi_fifo_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wd(ram_wd),
    .ram_raddr(ram_raddr), .ram_rd(ram_rd), .count(count)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wd;
    ram_rd <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Mid-cycle sample: occupancy, full rule, handshake effects on scoreboard.
  task automatic sample(output bit psh);
    chk("count", int'(count), sb.size());
    chk("count_max", int'(count <= 18), 1);
    chk("we_eq_push", int'(ram_we), int'(in_valid && in_ready));
    if (sb.size() >= 18) chk("full_rdy", int'(in_ready), 0);
    if (sb.size() == 0) chk("empty_vld", int'(out_valid), 0);
    if (stream) chk("no_bubble", int'(out_valid), 1);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious", int'(out_data), -1);
      else chk("data", int'(out_data), int'(sb.pop_front()));
    end
    psh = in_valid && in_ready;
    if (psh) sb.push_back(in_data);
  endtask

  task automatic cyc(input bit iv, input int d, input bit ordy, output bit psh);
    in_valid  = iv;
    in_data   = DATA_W'(d);
    out_ready = ordy;
    @(negedge clk);
    sample(psh);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit p;
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      cyc(1'b0, 0, 1'b1, p);
      n++;
    end
    chk("drain_done", sb.size(), 0);
    cyc(1'b0, 0, 1'b1, p);
  endtask

  task automatic fill(input int n, input int base);
    int k = 0;
    int t = 0;
    while (k < n && t < 100) begin
      cyc(1'b1, base + k, 1'b0, pushed);
      if (pushed) k++;
      t++;
    end
    chk("fill_done", k, n);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_waddr", int'(ram_waddr), 0);
    chk("rst_raddr", int'(ram_raddr), 0);
    chk("rst_count", int'(count), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("init_wait", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("init_rdy", int'(in_ready), 1);

    // Single word latency.
    cyc(1'b0, 0, 1'b0, pushed);
    cyc(1'b1, 'h155, 1'b0, pushed);
    chk("lat_e0", int'(out_valid), 0);
    cyc(1'b0, 0, 1'b0, pushed);
    chk("lat_e1", int'(out_valid), 0);
    cyc(1'b0, 0, 1'b0, pushed);
    chk("lat_e2", int'(out_valid), 1);
    chk("lat_data", int'(out_data), 'h155);
    chk("lat_cnt", int'(count), 1);
    drain();
    chk("lat_cnt0", int'(count), 0);

    // Fill to capacity then stream the drain.
    fill(18, 0);
    repeat (3) cyc(1'b1, 99, 1'b0, pushed);
    chk("full_cnt", int'(count), 18);
    chk("full_rdy_hi", int'(in_ready), 0);
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain_stream", int'(out_valid), 1);
      sample(pushed);
      @(posedge clk);
      #1;
    end
    drain();

    // Sustained push and pop.
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 'h200 + i, 1'b1, pushed);
      if (out_valid) stream = 1'b1;
    end
    stream = 1'b0;
    drain();

    // Randomised handshakes.
    begin
      int k = 0;
      int t = 0;
      while (k < 2000 && t < 20000) begin
        cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)),
            1'($urandom_range(0, 1)), pushed);
        if (pushed) k++;
        t++;
      end
      chk("rand_done", k, 2000);
    end
    drain();

    // Wrap pointers repeatedly while sitting at the full boundary.
    fill(18, 'h300);
    for (int i = 0; i < 3 * DEPTH; i++)
      cyc(1'b1, 'h400 + i, 1'b1, pushed);
    drain();

    // Asynchronous reset mid-operation.
    fill(10, 'h500);
    cyc(1'b0, 0, 1'b0, pushed);
    chk("pre_rst_cnt", int'(count), 10);
    rst = 1'b1;
    #1;
    chk("arst_vld", int'(out_valid), 0);
    chk("arst_rdy", int'(in_ready), 0);
    chk("arst_cnt", int'(count), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rel_rdy0", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("rel_rdy1", int'(in_ready), 1);
    cyc(1'b1, 'h7FF, 1'b0, pushed);
    cyc(1'b0, 0, 1'b0, pushed);
    cyc(1'b0, 0, 1'b0, pushed);
    chk("post_rst_vld", int'(out_valid), 1);
    chk("post_rst_data", int'(out_data), 'h7FF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
